// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the narrowing store path.
// Contents: word width, store size encoding, FSM state encoding and the
// alignment / legality helper used when a request is accepted.
package store_narrow_rmw_pkg;

   localparam int unsigned WordW = 32;

   typedef enum logic [1:0] {
      SizeB = 2'b00,
      SizeH = 2'b01,
      SizeW = 2'b10,
      SizeX = 2'b11
   } size_e;

   // FSM encoding kept as plain constants so older tools and netlists can match it.
   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StRd   = 3'd1;
   localparam logic [2:0] StMrg  = 3'd2;
   localparam logic [2:0] StWr   = 3'd3;
   localparam logic [2:0] StDone = 3'd4;

   // 1 when the request cannot be performed: illegal size or misaligned address.
   function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SizeB:   bad = 1'b0;
         SizeH:   bad = addr_lo[0];
         SizeW:   bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_narrow_rmw_if.sv
// Bus bundle between the MEM-stage store path, the narrowing store block and
// word-addressed data memory.
//   req_*   : store request handshake (valid/ready, byte address, data, size)
//   mem_*   : word memory port (address, read strobe, read data, write strobe, write data)
//   done_o, trunc_ovf_o, misalign_o : completion pulse and status
// Modport slave is the store block; master is the requester/memory side.
interface store_narrow_rmw_if
   import store_narrow_rmw_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [ADDR_W-1:0] req_addr_i;
   logic [WordW-1:0]  req_data_i;
   logic [1:0]        req_size_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_rd_o;
   logic [WordW-1:0]  mem_rdata_i;
   logic              mem_wr_o;
   logic [WordW-1:0]  mem_wdata_o;
   logic              done_o;
   logic              trunc_ovf_o;
   logic              misalign_o;

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, req_size_i, mem_rdata_i,
      output req_ready_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
      output done_o, trunc_ovf_o, misalign_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_data_i, req_size_i, mem_rdata_i,
      input  req_ready_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
      input  done_o, trunc_ovf_o, misalign_o
   );

endinterface

// File: rtl/store_narrow_rmw_lane_merge.sv
// Combinational little-endian lane merge for sub-word stores.
//   old_i       : current memory word
//   data_i      : register value to store
//   size_i      : byte / half / word / illegal
//   addr_lo_i   : byte offset within the word
//   merged_o    : old_i with the addressed lane(s) replaced by the narrowed data
//   trunc_ovf_o : data does not round-trip through sign extension from the store size
module store_narrow_rmw_lane_merge
   import store_narrow_rmw_pkg::*;
(
   input  logic [WordW-1:0] old_i,
   input  logic [WordW-1:0] data_i,
   input  size_e            size_i,
   input  logic [1:0]       addr_lo_i,
   output logic [WordW-1:0] merged_o,
   output logic             trunc_ovf_o
);

   always_comb begin
      merged_o    = old_i;
      trunc_ovf_o = 1'b0;
      case (size_i)
         SizeB: begin
            merged_o[{addr_lo_i, 3'b000} +: 8] = data_i[7:0];
            trunc_ovf_o = (data_i[31:8] != {24{data_i[7]}});
         end
         SizeH: begin
            if (addr_lo_i[1]) begin
               merged_o[31:16] = data_i[15:0];
            end else begin
               merged_o[15:0] = data_i[15:0];
            end
            trunc_ovf_o = (data_i[31:16] != {16{data_i[15]}});
         end
         SizeW:   merged_o = data_i;
         default: merged_o = old_i;
      endcase
   end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: writes byte/half/word stores into word-only memory,
// using read-modify-write for sub-word sizes. One request in flight.
//   clk_i  : clock
//   rst_i  : synchronous active-low reset
//   bus_io : request handshake, word memory port and completion status
// All memory strobes and status outputs come from registered state only.
module store_narrow_rmw
   import store_narrow_rmw_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   store_narrow_rmw_if.slave  bus_io
);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WordW-1:0]  data_q, data_d;
   size_e             size_q, size_d;
   logic [DATA_W-1:0] merged_q, merged_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;

   logic [WordW-1:0]  merge_word;
   logic              merge_ovf;

   store_narrow_rmw_lane_merge u_lane_merge (
      .old_i       (bus_io.mem_rdata_i),
      .data_i      (data_q),
      .size_i      (size_q),
      .addr_lo_i   (addr_q[1:0]),
      .merged_o    (merge_word),
      .trunc_ovf_o (merge_ovf)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      size_d   = size_q;
      merged_d = merged_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      case (state_q)
         StIdle: begin
            if (bus_io.req_valid_i) begin
               addr_d   = bus_io.req_addr_i;
               data_d   = bus_io.req_data_i;
               size_d   = size_e'(bus_io.req_size_i);
               err_d    = is_misaligned(size_e'(bus_io.req_size_i), bus_io.req_addr_i[1:0]);
               ovf_d    = 1'b0;
               // Word stores write the register value as-is; sub-word stores
               // overwrite this in the merge cycle.
               merged_d = bus_io.req_data_i;
               if (err_d) begin
                  state_d = StDone;
               end else if (size_e'(bus_io.req_size_i) == SizeW) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd:   state_d = StMrg;
         StMrg: begin
            merged_d = merge_word;
            ovf_d    = merge_ovf;
            state_d  = StWr;
         end
         StWr:    state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         data_q   <= '0;
         size_q   <= SizeB;
         merged_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         size_q   <= size_d;
         merged_q <= merged_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign bus_io.req_ready_o = (state_q == StIdle);
   assign bus_io.mem_rd_o    = (state_q == StRd);
   assign bus_io.mem_wr_o    = (state_q == StWr);
   assign bus_io.done_o      = (state_q == StDone);
   assign bus_io.trunc_ovf_o = (state_q == StDone) & ovf_q;
   assign bus_io.misalign_o  = (state_q == StDone) & err_q;
   assign bus_io.mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus_io.mem_wdata_o = merged_q;

endmodule
